// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   baud_tick    one-clock strobe at the bit rate
//   send         frame request, sampled only in IDLE
//   data_in      data word captured on acceptance
//   parity_bit   parity unit output for data_in, captured on acceptance
//   parity_type  00/11 none, 01 odd, 10 even
//   stop_bits    0 = one stop bit, 1 = two stop bits
//   data_tx      serial line, idles high
//   busy         high from acceptance until the frame completes
//   done_flag    one-clock pulse after the last stop bit
module uart_tx_frame (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic       parity_bit,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  output logic       data_tx,
  output logic       busy,
  output logic       done_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_stop_cnt;
  logic       r_parity_bit;
  logic [1:0] r_parity_type;
  logic       r_stop_bits;
  logic       r_tx;
  logic       r_busy;
  logic       r_done;
  logic       w_tx_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_par_en;
  logic       w_last_stop;
  logic       w_last_data;

  // Types 01 and 10 carry a parity slot; 00 and 11 do not.
  assign w_par_en    = r_parity_type[0] ^ r_parity_type[1];
  assign w_last_stop = (r_stop_cnt == r_stop_bits);
  assign w_last_data = (r_bit_cnt == 3'd7);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (send) w_state_nxt = S_LOAD;
      S_LOAD:   if (baud_tick) w_state_nxt = S_START;
      S_START:  if (baud_tick) w_state_nxt = S_DATA;
      S_DATA: begin
        if (baud_tick && w_last_data) w_state_nxt = w_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (baud_tick) w_state_nxt = S_STOP;
      S_STOP:   if (baud_tick && w_last_stop) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; each bit is launched on the tick
  // edge that ends the previous one.
  always_comb begin
    w_tx_nxt   = r_tx;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE:   if (send) w_busy_nxt = 1'b1;
      S_LOAD:   if (baud_tick) w_tx_nxt = 1'b0;
      S_START:  if (baud_tick) w_tx_nxt = r_shift[0];
      S_DATA: begin
        if (baud_tick) begin
          if (!w_last_data) w_tx_nxt = r_shift[0];
          else              w_tx_nxt = w_par_en ? r_parity_bit : 1'b1;
        end
      end
      S_PARITY: if (baud_tick) w_tx_nxt = 1'b1;
      S_STOP: begin
        if (baud_tick && w_last_stop) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx          <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shift       <= 8'd0;
      r_bit_cnt     <= 3'd0;
      r_stop_cnt    <= 1'b0;
      r_parity_bit  <= 1'b0;
      r_parity_type <= 2'd0;
      r_stop_bits   <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      case (r_state)
        S_IDLE: begin
          if (send) begin
            r_shift       <= data_in;
            r_parity_bit  <= parity_bit;
            r_parity_type <= parity_type;
            r_stop_bits   <= stop_bits;
          end
        end
        S_START: begin
          if (baud_tick) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= 3'd0;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (!w_last_data) begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (!w_par_en) begin
              r_stop_cnt <= 1'b0;
            end
          end
        end
        S_PARITY: if (baud_tick) r_stop_cnt <= 1'b0;
        S_STOP:   if (baud_tick && !w_last_stop) r_stop_cnt <= r_stop_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign data_tx   = r_tx;
  assign busy      = r_busy;
  assign done_flag = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard testbench for uart_tx_frame
module tb_uart_tx_frame;

  logic       clock;
  logic       reset_n;
  logic       baud_tick;
  logic       send;
  logic [7:0] data_in;
  logic       parity_bit;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_tx;
  logic       busy;
  logic       done_flag;

  uart_tx_frame dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_tick   (baud_tick),
    .send        (send),
    .data_in     (data_in),
    .parity_bit  (parity_bit),
    .parity_type (parity_type),
    .stop_bits   (stop_bits),
    .data_tx     (data_tx),
    .busy        (busy),
    .done_flag   (done_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tick generator: 0 = manual, 1 = periodic, 2 = continuous.
  int   tick_mode = 0;
  int   tick_period = 16;
  int   tick_cnt = 0;
  logic man_tick = 1'b0;
  initial baud_tick = 1'b0;
  always @(negedge clock) begin
    case (tick_mode)
      0: baud_tick = man_tick;
      1: begin
        baud_tick = (tick_cnt == 0);
        tick_cnt  = (tick_cnt >= tick_period - 1) ? 0 : tick_cnt + 1;
      end
      default: baud_tick = 1'b1;
    endcase
  end

  logic tick_q = 1'b0;
  always @(posedge clock) tick_q <= baud_tick;

  // Scoreboard entry: {length[3:0], bits[12:0]}, first transmitted bit is the MSB of the used bits.
  logic [16:0] exp_q[$];
  logic [16:0] cur_exp;
  logic [12:0] rx_bits;
  int          rx_cnt = 0;
  bit          rx_active = 0;
  bit          done_due = 0;
  int          m_checks = 0;
  int          m_errors = 0;
  int          s_checks = 0;
  int          s_errors = 0;

  // Monitor: behaves as a receiver sampling the line after every tick edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      rx_active = 0;
      done_due  = 0;
    end else begin
      if (done_flag && !(done_due && tick_q)) begin
        m_checks++;
        m_errors++;
        $display("FAIL done_unexpected: done_flag=1 required=0 at %0t", $time);
      end
      if (tick_q) begin
        if (done_due) begin
          m_checks++;
          if (!done_flag || busy) begin
            m_errors++;
            $display("FAIL done_pulse: done_flag=%0b busy=%0b required done_flag=1 busy=0 at %0t",
                     done_flag, busy, $time);
          end
          done_due = 0;
        end
        if (rx_active) begin
          rx_bits = {rx_bits[11:0], data_tx};
          rx_cnt++;
          if (rx_cnt == int'(cur_exp[16:13])) begin
            m_checks++;
            if (rx_bits != cur_exp[12:0]) begin
              m_errors++;
              $display("FAIL frame: got=%b required=%b (len %0d) at %0t",
                       rx_bits, cur_exp[12:0], cur_exp[16:13], $time);
            end
            rx_active = 0;
            done_due  = 1;
          end
        end else if (data_tx == 1'b0) begin
          if (exp_q.size() == 0) begin
            m_checks++;
            m_errors++;
            $display("FAIL frame_unexpected: start bit seen, none required at %0t", $time);
            cur_exp = {4'd10, 13'd0};
          end else begin
            cur_exp = exp_q.pop_front();
          end
          rx_active = 1;
          rx_bits   = 13'd0;
          rx_cnt    = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    s_checks++;
    if (act !== req) begin
      s_errors++;
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] t, input logic s,
                            input logic [3:0] len, input logic [12:0] bits);
    for (int i = 0; i < 1000 && busy; i++) step();
    data_in     = d;
    parity_bit  = p;
    parity_type = t;
    stop_bits   = s;
    send        = 1'b1;
    exp_q.push_back({len, bits});
    step();
    send        = 1'b0;
    data_in     = 8'($urandom);
    parity_bit  = 1'($urandom);
    parity_type = 2'($urandom);
    stop_bits   = 1'($urandom);
    check("busy_after_accept", {7'd0, busy}, 8'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (done_flag) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      s_checks++;
      s_errors++;
      $display("FAIL %s: done_flag=0 required=1 within 600 clocks", name);
    end
  endtask

  task automatic measure(input int exp_n, input string name);
    int n;
    bit seen;
    seen = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (data_tx == 1'b0) begin
        seen = 1;
        break;
      end
      step();
    end
    if (seen) begin
      for (int i = 0; i < 400; i++) begin
        step();
        n++;
        if (done_flag) break;
      end
    end
    s_checks++;
    if (!seen || n != exp_n) begin
      s_errors++;
      $display("FAIL %s: clocks=%0d required=%0d", name, n, exp_n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    send        = 1'b0;
    data_in     = 8'd0;
    parity_bit  = 1'b0;
    parity_type = 2'd0;
    stop_bits   = 1'b0;
    repeat (3) step();
    check("reset_data_tx", {7'd0, data_tx}, 8'd1);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_done", {7'd0, done_flag}, 8'd0);
    reset_n = 1'b1;
    step();

    // Reset in the middle of a 0x00 frame.
    tick_mode   = 1;
    tick_period = 8;
    send_frame(8'h00, 1'b0, 2'b00, 1'b0, 4'd10, 13'b0000000001);
    repeat (40) step();
    check("mid_data_line", {7'd0, data_tx}, 8'd0);
    reset_n = 1'b0;
    #1;
    check("async_reset_data_tx", {7'd0, data_tx}, 8'd1);
    check("async_reset_busy", {7'd0, busy}, 8'd0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (100) step();
    check("post_reset_busy", {7'd0, busy}, 8'd0);
    check("post_reset_data_tx", {7'd0, data_tx}, 8'd1);

    // 0xA5 odd parity, one stop bit, tick every 16 clocks.
    tick_period = 16;
    send_frame(8'hA5, 1'b1, 2'b01, 1'b0, 4'd11, 13'b01010010111);
    measure(176, "a5_odd_frame_clocks");

    // 0x07 even parity.
    send_frame(8'h07, 1'b1, 2'b10, 1'b0, 4'd11, 13'b01110000011);
    wait_done("even_07");

    // 0x00, type 11 (no parity), two stop bits; parity input must be ignored.
    tick_period = 4;
    send_frame(8'h00, 1'b1, 2'b11, 1'b1, 4'd11, 13'b00000000011);
    wait_done("none_2stop_00");

    // Busy send ignored, then back-to-back send in the done cycle.
    tick_period = 8;
    send_frame(8'h5A, 1'b0, 2'b10, 1'b0, 4'd11, 13'b00101101001);
    repeat (20) step();
    data_in = 8'hFF;
    send    = 1'b1;
    step();
    send    = 1'b0;
    wait_done("even_5a");
    send_frame(8'h3C, 1'b0, 2'b00, 1'b1, 4'd11, 13'b00011110011);
    wait_done("b2b_3c");

    // Tick coincident with acceptance does not launch the start bit.
    tick_mode = 0;
    man_tick  = 1'b1;
    send_frame(8'h81, 1'b1, 2'b01, 1'b0, 4'd11, 13'b01000000111);
    man_tick  = 1'b0;
    repeat (4) step();
    check("coincident_tick_line", {7'd0, data_tx}, 8'd1);
    check("coincident_tick_busy", {7'd0, busy}, 8'd1);
    tick_mode   = 1;
    tick_period = 4;
    wait_done("odd_81");

    // Continuous ticks: one bit per clock.
    tick_mode = 2;
    send_frame(8'hA5, 1'b1, 2'b01, 1'b0, 4'd11, 13'b01010010111);
    measure(11, "continuous_odd_clocks");
    send_frame(8'h0F, 1'b0, 2'b10, 1'b1, 4'd12, 13'b011110000011);
    measure(12, "continuous_even_2stop_clocks");

    tick_mode = 1;
    repeat (40) step();
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    check("receiver_idle", {7'd0, rx_active}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", s_checks + m_checks, s_errors + m_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmit framer and serializer. It sits directly downstream of the `Parity` unit. When a send request arrives, it captures the 8-bit data word, the `Parity` output bit and the frame configuration. It then shifts out a complete frame on the serial line, one bit per baud tick: start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It reports busy and done status to the transmit controller.

## Interface

Parameters:
- none; the frame format is fixed at 8 data bits. Parity and stop-bit count are selected per frame through ports.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `baud_tick`  in  1  one-clock-wide strobe at the bit rate, from the baud generator.
- `send`  in  1  frame request; sampled only while idle.
- `data_in`  in  8  data word; the same bus that feeds the `Parity` unit.
- `parity_bit`  in  1  `Parity` unit output for `data_in`.
- `parity_type`  in  2  00/11 = no parity, 01 = odd, 10 = even.
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `data_tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is accepted or in flight.
- `done_flag`  out  1  one-clock pulse when a frame completes.

## Operation

- **States:** IDLE, LOAD, START, DATA, PARITY, STOP.
- **IDLE:**
  - When `send`=1, capture `data_in` into an 8-bit shift register.
  - Also capture `parity_bit`, `parity_type` and `stop_bits`.
  - Go to LOAD and set `busy`=1.
  - `data_in`, `parity_bit` and the configuration inputs are don't-care after the capture edge.
- **LOAD:** waits for `baud_tick`, so every frame bit is exactly one tick period long. On the tick, `data_tx`←0 and go to START.
- **START:** on tick, `data_tx`←shift[0], shift right, `bit_cnt`←0, go to DATA.
- **DATA:** on tick:
  - If `bit_cnt`<7: `data_tx`←shift[0], shift, `bit_cnt`+1.
  - If `bit_cnt`=7 and captured type is 01 or 10: `data_tx`←captured parity bit, go to PARITY.
  - If `bit_cnt`=7 and captured type is 00 or 11: `data_tx`←1, `stop_cnt`←0, go to STOP.
- **PARITY:** on tick, `data_tx`←1, `stop_cnt`←0, go to STOP.
- **STOP:** on tick:
  - If `stop_cnt` equals (captured `stop_bits` ? 1 : 0): go to IDLE, `busy`←0, `done_flag`←1 for one clock. `data_tx` stays 1.
  - Otherwise `stop_cnt`+1.
- **Outside IDLE:**
  - `send` is ignored; no queuing.
  - `baud_tick` is ignored in IDLE.
- **Counter widths:** `bit_cnt` is 3 bits; `stop_cnt` is 1 bit.
- **Frame length:** 10 + P + S bits, where P is 0 or 1 (parity) and S is 0 or 1 (second stop bit).

## Timing

- **Reset values (async, held while `reset_n`=0):**
  - `data_tx`=1, `busy`=0, `done_flag`=0.
  - State IDLE; counters and shift register 0.
- **Reset mid-frame:** `data_tx` returns high immediately, no `done_flag` pulse, captured frame discarded.
- **Latencies (all outputs registered):**
  - `send` accepted at edge E gives `busy`=1 after E.
  - The start bit begins on the edge of the first `baud_tick` after E.
- **Tick coincident with acceptance:** a `baud_tick` high in the same cycle as accepted `send` does not start the frame. The state is still IDLE, so the start waits for the next tick.
- **Bit timing:** each bit occupies the clocks from one tick edge to the next.
- **Done pulse:**
  - `done_flag` is high for the clock following the tick that ends the last stop bit.
  - `busy` falls on that same edge.
- **Back-to-back frames:** `send` high in the `done_flag` cycle is accepted, since the state is IDLE then. Line gap ≥ 0 extra ticks beyond the LOAD wait.
- **Tick rate:** `baud_tick` in consecutive clocks is legal; each tick advances one bit.

## Test plan

- **Reset:** assert `reset_n`=0 mid-DATA, data 0x00 → `data_tx`=1, `busy`=0 asynchronously; release → idle, no `done_flag`.
- **Odd parity, 1 stop:** `data_in`=0xA5, odd parity, 1 stop, tick every 16 clocks.
  - Line sequence 0,1,0,1,0,0,1,0,1,1,1.
  - `done_flag` 176 clocks after the first tick edge.
- **Even parity:** `data_in`=0x07, even parity, 1 stop → 0,1,1,1,0,0,0,0,0,1,1.
- **No parity, 2 stop:** type 11, 2 stop, `data_in`=0x00 → 0, eight 0s, 1,1 (11 bits), no parity slot.
- **Busy and back-to-back:**
  - `send` pulsed while `busy`=1 → ignored, frame unchanged.
  - `send` in the `done_flag` cycle with 0x3C → second frame starts at the next tick.
- **Tick alignment:** `send` and `baud_tick` in the same cycle → start bit waits for the next tick.
  - `baud_tick` held high continuously → 11-clock frame for odd parity, 1 stop.
